// File: rtl/alu_pkg.sv
// Shared constants and FSM state type for the ALU control stage.
package alu_pkg;

    localparam int DATA_W  = 8;
    localparam int OP_W    = 4;
    localparam int NUM_OPS = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_AND = 4'd1;
    localparam logic [OP_W-1:0] OP_OR  = 4'd2;
    localparam logic [OP_W-1:0] OP_XOR = 4'd3;

    // Collect A, collect B, collect opcode, capture result, offer result.
    typedef enum logic [2:0] {
        S_A,
        S_B,
        S_OP,
        S_EXEC,
        S_OUT
    } state_t;

endpackage

// File: rtl/alu_op_sequencer.sv
// Three-beat operand collector in front of alu_8bit, with a registered
// result port carrying zero and illegal-opcode flags.
module alu_op_sequencer #(
    parameter int DATA_W  = alu_pkg::DATA_W,
    parameter int OP_W    = alu_pkg::OP_W,
    parameter int NUM_OPS = alu_pkg::NUM_OPS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] out_data,
    output logic              out_zero,
    output logic              out_err,
    output logic              out_valid,
    input  logic              out_ready
);

    import alu_pkg::*;

    state_t state;

    // Handshake flags are pure decodes of the state register, so they are
    // glitch-free and in_ready is already high while rst is held.
    assign in_ready  = (state == S_A) || (state == S_B) || (state == S_OP);
    assign out_valid = (state == S_OUT);

    // Sequencer and datapath registers; abort only rewinds the state and
    // deliberately leaves operands and the last result untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_A;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            out_data   <= '0;
            out_zero   <= 1'b0;
            out_err    <= 1'b0;
        end else if (abort) begin
            state <= S_A;
        end else begin
            case (state)
                S_A: begin
                    if (in_valid) begin
                        alu_a <= in_data;
                        state <= S_B;
                    end
                end
                S_B: begin
                    if (in_valid) begin
                        alu_b <= in_data;
                        state <= S_OP;
                    end
                end
                S_OP: begin
                    if (in_valid) begin
                        alu_opcode <= in_data[OP_W-1:0];
                        state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    out_data <= alu_result;
                    out_zero <= (alu_result == '0);
                    out_err  <= (32'(alu_opcode) >= 32'(NUM_OPS));
                    state    <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        state <= S_A;
                    end
                end
                default: begin
                    state <= S_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a behavioural ALU closes the loop,
// expected results go into a scoreboard queue and a negedge monitor
// compares them whenever a result is handed over.
module tb_alu_op_sequencer;

    logic       clk;
    logic       rst;
    logic       abort;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_opcode;
    logic [7:0] alu_result;
    logic [7:0] out_data;
    logic       out_zero;
    logic       out_err;
    logic       out_valid;
    logic       out_ready;

    typedef struct {
        logic [7:0] data;
        logic       zero;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    alu_op_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .abort      (abort),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .out_data   (out_data),
        .out_zero   (out_zero),
        .out_err    (out_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for alu_8bit: four legal ops, anything else yields zero.
    always_comb begin
        alu_result = 8'h00;
        case (alu_opcode)
            4'd0: alu_result = alu_a + alu_b;
            4'd1: alu_result = alu_a & alu_b;
            4'd2: alu_result = alu_a | alu_b;
            4'd3: alu_result = alu_a ^ alu_b;
            default: alu_result = 8'h00;
        endcase
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%02h expected=0x%02h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=timeout expected=event", name);
    endtask

    // Offer one beat at posedge+1 and hold it until an edge accepts it.
    task automatic sendBeat(input logic [7:0] d);
        int n;
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) failNow("beat_accept");
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                                 input logic [7:0] expData, input logic expZero, input logic expErr);
        exp_t e;
        e.data = expData;
        e.zero = expZero;
        e.err  = expErr;
        sb.push_back(e);
        sendBeat(a);
        sendBeat(b);
        sendBeat(op);
    endtask

    // Wait until the scoreboard has drained and the sequencer is back in S_A.
    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0 || !in_ready) failNow(name);
    endtask

    // Scoreboard monitor: every result handshake pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                failNow("unexpected_result");
            end else begin
                e = sb.pop_front();
                checkOutput("out_data", out_data, e.data);
                checkOutput("out_zero", {7'b0, out_zero}, {7'b0, e.zero});
                checkOutput("out_err", {7'b0, out_err}, {7'b0, e.err});
            end
        end
    end

    initial begin
        int n;
        rst       = 1'b1;
        abort     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        #12;
        checkOutput("rst_in_ready", {7'b0, in_ready}, 8'h01);
        checkOutput("rst_out_valid", {7'b0, out_valid}, 8'h00);
        checkOutput("rst_alu_a", alu_a, 8'h00);
        checkOutput("rst_out_data", out_data, 8'h00);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] add with latency check");
        applyStimulus(8'h3C, 8'h05, 8'h00, 8'h41, 1'b0, 1'b0);
        checkOutput("lat_exec_out_valid", {7'b0, out_valid}, 8'h00);
        @(posedge clk); #1;
        checkOutput("lat_out_valid", {7'b0, out_valid}, 8'h01);
        waitIdle("idle_add");

        $display("[TB] wrap, and, illegal, xor back to back");
        applyStimulus(8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0);
        applyStimulus(8'hF0, 8'h0F, 8'h01, 8'h00, 1'b1, 1'b0);
        applyStimulus(8'hAA, 8'h55, 8'hF5, 8'h00, 1'b1, 1'b1);
        checkOutput("opcode_low_nibble", {4'b0, alu_opcode}, 8'h05);
        applyStimulus(8'hAA, 8'h55, 8'h03, 8'hFF, 1'b0, 1'b0);
        waitIdle("idle_b2b");

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(8'h12, 8'h34, 8'h02, 8'h36, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) failNow("bp_out_valid_rise");
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_out_valid", {7'b0, out_valid}, 8'h01);
            checkOutput("bp_out_data", out_data, 8'h36);
            checkOutput("bp_in_ready", {7'b0, in_ready}, 8'h00);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_release_in_ready", {7'b0, in_ready}, 8'h01);
        checkOutput("bp_release_out_valid", {7'b0, out_valid}, 8'h00);
        checkOutput("bp_persist_out_data", out_data, 8'h36);

        $display("[TB] abort after A beat");
        sendBeat(8'h77);
        in_data  = 8'h99;
        in_valid = 1'b1;
        abort    = 1'b1;
        @(posedge clk); #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        checkOutput("abort_alu_a", alu_a, 8'h77);
        checkOutput("abort_alu_b", alu_b, 8'h34);
        checkOutput("abort_out_valid", {7'b0, out_valid}, 8'h00);
        applyStimulus(8'h01, 8'h02, 8'h00, 8'h03, 1'b0, 1'b0);
        waitIdle("idle_abort");
        checkOutput("post_abort_alu_a", alu_a, 8'h01);

        $display("[TB] async reset during S_B");
        sendBeat(8'h55);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_alu_a", alu_a, 8'h00);
        checkOutput("arst_alu_b", alu_b, 8'h00);
        checkOutput("arst_out_data", out_data, 8'h00);
        checkOutput("arst_in_ready", {7'b0, in_ready}, 8'h01);
        checkOutput("arst_out_valid", {7'b0, out_valid}, 8'h00);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus(8'h10, 8'h20, 8'h02, 8'h30, 1'b0, 1'b0);
        waitIdle("idle_final");

        checkOutput("sb_empty", 8'(sb.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
